// File: rtl/stepper_array_ctrl.sv
// stepper_array_ctrl: multi-channel step/dir pulse generator driven by a shared command port
//
// Ports:
//   system1000      clock
//   system1000_rst  asynchronous active-high reset
//   cmd_valid       command strobe, one command per cycle
//   cmd_chan        target channel index
//   cmd_op          0=SET_TARGET, 1=SET_PERIOD, 2=SET_POS, 3=STOP
//   cmd_data        operand; SET_PERIOD uses the low PER_W bits
//   step            per-channel step pulses
//   dir             per-channel direction, 1 = increasing position
//   busy            per-channel moving or pos != target
//   done            per-channel 1-cycle arrival pulse
//   cmd_err         1-cycle pulse when a command is rejected
//   active_count    number of busy channels, one cycle behind busy
module stepper_array_ctrl #(
    parameter int CHANNELS       = 30,
    parameter int POS_W          = 16,
    parameter int PER_W          = 16,
    parameter int SETUP_CYCLES   = 2,
    parameter int PULSE_CYCLES   = 4,
    parameter int DEFAULT_PERIOD = 1000,
    parameter int CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                            system1000,
    input  logic                            system1000_rst,
    input  logic                            cmd_valid,
    input  logic [CH_W-1:0]                 cmd_chan,
    input  logic [1:0]                      cmd_op,
    input  logic [POS_W-1:0]                cmd_data,
    output logic [CHANNELS-1:0]             step,
    output logic [CHANNELS-1:0]             dir,
    output logic [CHANNELS-1:0]             busy,
    output logic [CHANNELS-1:0]             done,
    output logic                            cmd_err,
    output logic [$clog2(CHANNELS+1)-1:0]   active_count
);
    localparam int AC_W  = $clog2(CHANNELS + 1);
    localparam int SU_W  = $clog2(SETUP_CYCLES + 1);
    localparam int PU_W  = $clog2(PULSE_CYCLES + 1);
    localparam int SP_W  = (SU_W > PU_W) ? SU_W : PU_W;
    localparam int CNT_W = (PER_W > SP_W) ? PER_W : SP_W;
    localparam logic [CH_W:0] LP_CHN = (CH_W + 1)'(CHANNELS);
    localparam logic [1:0] OP_TGT = 2'd0, OP_PER = 2'd1, OP_POS = 2'd2, OP_STOP = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_HIGH, ST_LOW} state_t;

    logic [CHANNELS-1:0] w_err_ch;
    logic [AC_W-1:0]     w_pop;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        localparam logic [CH_W:0] LP_IDX = (CH_W + 1)'(g);
        state_t           r_state, w_state;
        logic [CNT_W-1:0] r_cnt, w_cnt, w_low;
        logic [POS_W-1:0] r_pos, w_pos, r_tgt, w_tgt, w_pos_step;
        logic [PER_W-1:0] r_per, w_per;
        logic             r_dir, w_dir, r_step, r_busy, r_done, w_done;
        logic             w_sel, w_stop, w_setpos;

        assign w_sel      = cmd_valid && ({1'b0, cmd_chan} == LP_IDX);
        assign w_stop     = w_sel && (cmd_op == OP_STOP);
        assign w_setpos   = w_sel && (cmd_op == OP_POS);
        assign w_pos_step = r_pos + (r_dir ? POS_W'(1) : {POS_W{1'b1}});
        // LOW lasts max(period,1) cycles; counter holds remaining cycles minus one
        assign w_low      = (r_per == '0) ? '0 : CNT_W'(r_per - 1'b1);
        assign w_err_ch[g] = w_setpos && (r_state != ST_IDLE);

        always_comb begin
            w_state = r_state;
            w_cnt   = r_cnt;
            w_pos   = r_pos;
            w_tgt   = r_tgt;
            w_per   = r_per;
            w_dir   = r_dir;
            w_done  = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // STOP and SET_POS hold the channel idle so motion is judged on the updated values
                    if (w_stop) w_tgt = r_pos;
                    else if (w_setpos) w_pos = cmd_data;
                    else if (r_pos != r_tgt) begin
                        w_dir   = $signed(r_tgt) > $signed(r_pos);
                        w_state = ST_SETUP;
                        w_cnt   = CNT_W'(SETUP_CYCLES - 1);
                    end
                end
                ST_SETUP: begin
                    if (w_stop) begin
                        w_state = ST_IDLE;
                        w_tgt   = r_pos;
                    end else if (r_cnt == '0) begin
                        w_state = ST_HIGH;
                        w_cnt   = CNT_W'(PULSE_CYCLES - 1);
                    end else w_cnt = r_cnt - 1'b1;
                end
                ST_HIGH: begin
                    // the in-flight pulse always finishes, so stop at the position it reaches
                    if (w_stop) w_tgt = w_pos_step;
                    if (r_cnt == '0) begin
                        w_state = ST_LOW;
                        w_pos   = w_pos_step;
                        w_cnt   = w_low;
                    end else w_cnt = r_cnt - 1'b1;
                end
                default: begin
                    if (w_stop) w_tgt = r_pos;
                    if (r_cnt == '0) begin
                        w_state = ST_IDLE;
                        w_done  = (r_pos == r_tgt) || w_stop;
                    end else w_cnt = r_cnt - 1'b1;
                end
            endcase
            if (w_sel && (cmd_op == OP_TGT)) w_tgt = cmd_data;
            if (w_sel && (cmd_op == OP_PER)) w_per = cmd_data[PER_W-1:0];
        end

        always_ff @(posedge system1000 or posedge system1000_rst) begin
            if (system1000_rst) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_pos   <= '0;
                r_tgt   <= '0;
                r_per   <= PER_W'(DEFAULT_PERIOD);
                r_dir   <= 1'b0;
                r_step  <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                r_state <= w_state;
                r_cnt   <= w_cnt;
                r_pos   <= w_pos;
                r_tgt   <= w_tgt;
                r_per   <= w_per;
                r_dir   <= w_dir;
                r_step  <= (w_state == ST_HIGH);
                r_busy  <= (w_state != ST_IDLE) || (w_pos != w_tgt);
                r_done  <= w_done;
            end
        end

        assign step[g] = r_step;
        assign dir[g]  = r_dir;
        assign busy[g] = r_busy;
        assign done[g] = r_done;
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < CHANNELS; i++) w_pop = w_pop + AC_W'(busy[i]);
    end

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            cmd_err      <= 1'b0;
            active_count <= '0;
        end else begin
            cmd_err      <= (cmd_valid && ({1'b0, cmd_chan} >= LP_CHN)) || (|w_err_ch);
            active_count <= w_pop;
        end
    end
endmodule

// File: tb/tb_stepper_array_ctrl.sv
// tb_stepper_array_ctrl: directed and random stimulus against a timeline reference model
module tb_stepper_array_ctrl;
    localparam int CH = 5, PW = 16, RW = 16, S = 2, P = 4, DP = 12, CW = 3, AW = 3;

    logic clk = 1'b0, rst = 1'b1, cv = 1'b0;
    logic [CW-1:0] cc = '0;
    logic [1:0] op = '0;
    logic [PW-1:0] cd = '0;
    logic [CH-1:0] step, dir, busy, done;
    logic err;
    logic [AW-1:0] ac;

    stepper_array_ctrl #(
        .CHANNELS(CH), .POS_W(PW), .PER_W(RW), .SETUP_CYCLES(S),
        .PULSE_CYCLES(P), .DEFAULT_PERIOD(DP)
    ) dut (
        .system1000(clk), .system1000_rst(rst), .cmd_valid(cv), .cmd_chan(cc),
        .cmd_op(op), .cmd_data(cd), .step(step), .dir(dir), .busy(busy),
        .done(done), .cmd_err(err), .active_count(ac)
    );

    always #5 clk = ~clk;

    logic [PW-1:0] m_pos[CH], m_tgt[CH];
    logic [RW-1:0] m_per[CH];
    logic          m_dir[CH];
    int            m_t[CH], m_low[CH];
    logic [CH-1:0] e_step, e_dir, e_busy, e_done, prev_step;
    logic          e_err;
    logic [AW-1:0] e_ac;
    int n_chk = 0, n_err = 0, cyc = 0;
    int rises[CH], highs[CH], dones[CH], last_rise[CH], gap[CH];
    logic [1:0] ro;
    logic [CW-1:0] rc;
    logic [PW-1:0] rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < CH; i++) begin
            m_pos[i] = '0; m_tgt[i] = '0; m_per[i] = RW'(DP); m_dir[i] = 1'b0;
            m_t[i] = -1; m_low[i] = 1;
        end
        e_step = '0; e_dir = '0; e_busy = '0; e_done = '0; e_err = 1'b0; e_ac = '0;
    endtask

    // m_t counts cycles since a step began: [0,S) setup, [S,S+P) pulse high, then m_low cycles low; -1 = at rest
    task automatic m_tick(input logic v, input logic [CW-1:0] c, input logic [1:0] o, input logic [PW-1:0] d);
        logic sel, stp;
        logic [PW-1:0] mv;
        int t0;
        e_ac = AW'($countones(e_busy));
        e_err = v && (int'(c) >= CH);
        e_done = '0;
        for (int i = 0; i < CH; i++) begin
            sel = v && (int'(c) == i);
            stp = sel && (o == 2'd3);
            mv = m_dir[i] ? m_pos[i] + 16'd1 : m_pos[i] - 16'd1;
            t0 = m_t[i];
            if (t0 < 0) begin
                if (stp) m_tgt[i] = m_pos[i];
                else if (sel && o == 2'd2) m_pos[i] = d;
                else if (m_pos[i] != m_tgt[i]) begin
                    m_dir[i] = $signed(m_tgt[i]) > $signed(m_pos[i]);
                    m_t[i] = 0;
                end
            end else if (t0 < S) begin
                if (stp) begin
                    m_t[i] = -1;
                    m_tgt[i] = m_pos[i];
                end else m_t[i]++;
            end else if (t0 < S + P) begin
                if (stp) m_tgt[i] = mv;
                if (t0 == S + P - 1) begin
                    m_pos[i] = mv;
                    m_low[i] = (m_per[i] == 0) ? 1 : int'(m_per[i]);
                end
                m_t[i]++;
            end else begin
                if (t0 == S + P + m_low[i] - 1) begin
                    e_done[i] = (m_pos[i] == m_tgt[i]) || stp;
                    m_t[i] = -1;
                end else m_t[i]++;
                if (stp) m_tgt[i] = m_pos[i];
            end
            if (sel && o == 2'd2 && t0 >= 0) e_err = 1'b1;
            if (sel && o == 2'd0) m_tgt[i] = d;
            if (sel && o == 2'd1) m_per[i] = d;
            e_step[i] = (m_t[i] >= S) && (m_t[i] < S + P);
            e_dir[i]  = m_dir[i];
            e_busy[i] = (m_t[i] >= 0) || (m_pos[i] != m_tgt[i]);
        end
    endtask

    task automatic tick(input logic v, input logic [CW-1:0] c, input logic [1:0] o, input logic [PW-1:0] d);
        cv = v; cc = c; op = o; cd = d;
        m_tick(v, c, o, d);
        @(negedge clk);
        cyc++;
        chk("step", 32'(step), 32'(e_step));
        chk("dir", 32'(dir), 32'(e_dir));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("cmd_err", 32'(err), 32'(e_err));
        chk("active_count", 32'(ac), 32'(e_ac));
        for (int i = 0; i < CH; i++) begin
            if (step[i] && !prev_step[i]) begin
                if (last_rise[i] >= 0) gap[i] = cyc - last_rise[i];
                last_rise[i] = cyc;
                rises[i]++;
            end
            if (step[i]) highs[i]++;
            if (done[i]) dones[i]++;
        end
        prev_step = step;
        cv = 1'b0;
    endtask

    task automatic clr();
        for (int i = 0; i < CH; i++) begin
            rises[i] = 0; highs[i] = 0; dones[i] = 0; last_rise[i] = -1; gap[i] = 0;
        end
    endtask

    task automatic settle(input int lim);
        for (int k = 0; k < lim && e_busy != 0; k++) tick(1'b0, '0, 2'd0, '0);
        chk("settle_busy", 32'(busy), 32'd0);
        tick(1'b0, '0, 2'd0, '0);
        tick(1'b0, '0, 2'd0, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        m_reset();
        prev_step = '0;
        clr();
        @(negedge clk);
        @(negedge clk);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dir", 32'(dir), 32'd0);
        chk("rst_ac", 32'(ac), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) tick(1'b1, CW'(c), 2'd1, 16'd10);
        tick(1'b0, '0, 2'd0, '0);

        clr();
        tick(1'b1, 3'd1, 2'd0, 16'd3);
        settle(300);
        chk("ch1_rises", rises[1], 3);
        chk("ch1_gap", gap[1], 17);
        chk("ch1_high", highs[1], 12);
        chk("ch1_done", dones[1], 1);

        clr();
        tick(1'b1, 3'd0, 2'd0, 16'hFFFE);
        settle(300);
        chk("ch0_rises", rises[0], 2);
        chk("ch0_done", dones[0], 1);
        chk("ch0_dir", 32'(dir[0]), 32'd0);

        clr();
        tick(1'b1, 3'd2, 2'd0, 16'd10);
        for (int k = 0; k < 200 && rises[2] < 4; k++) tick(1'b0, '0, 2'd0, '0);
        tick(1'b1, 3'd2, 2'd3, '0);
        settle(300);
        chk("ch2_rises", rises[2], 4);
        chk("ch2_high", highs[2], 16);
        chk("ch2_done", dones[2], 1);

        tick(1'b1, 3'd3, 2'd0, 16'd3);
        for (int k = 0; k < 100 && m_t[3] < S + P; k++) tick(1'b0, '0, 2'd0, '0);
        tick(1'b1, 3'd3, 2'd2, 16'd99);
        chk("setpos_low_err", 32'(err), 32'd1);
        settle(300);
        tick(1'b1, 3'd3, 2'd0, 16'd0);
        settle(300);
        clr();
        tick(1'b1, 3'd3, 2'd2, 16'd5);
        tick(1'b0, '0, 2'd0, '0);
        tick(1'b0, '0, 2'd0, '0);
        chk("ch3_dir", 32'(dir[3]), 32'd0);
        settle(300);
        chk("ch3_rises", rises[3], 5);
        chk("ch3_done", dones[3], 1);

        tick(1'b1, 3'd7, 2'd0, 16'd5);
        chk("bad_chan_err", 32'(err), 32'd1);
        tick(1'b0, '0, 2'd0, '0);

        for (int k = 0; k < 600; k++) begin
            ro = 2'($urandom_range(0, 3));
            rc = ($urandom_range(0, 9) == 0) ? 3'd7 : CW'($urandom_range(0, CH - 1));
            rd = (ro == 2'd1) ? PW'($urandom_range(0, 6)) : PW'($urandom_range(0, 16)) - 16'd8;
            tick($urandom_range(0, 2) == 0, rc, ro, rd);
        end
        settle(3000);

        for (int c = 0; c < CH; c++) tick(1'b1, CW'(c), 2'd0, PW'(c + 20));
        for (int k = 0; k < 50 && step == 0; k++) tick(1'b0, '0, 2'd0, '0);
        chk("pre_rst_step", 32'(|step), 32'd1);
        #2 rst = 1'b1;
        #1 chk("rst_async_step", 32'(step), 32'd0);
        @(negedge clk);
        chk("rst2_step", 32'(step), 32'd0);
        chk("rst2_dir", 32'(dir), 32'd0);
        chk("rst2_busy", 32'(busy), 32'd0);
        chk("rst2_done", 32'(done), 32'd0);
        chk("rst2_err", 32'(err), 32'd0);
        chk("rst2_ac", 32'(ac), 32'd0);
        m_reset();
        prev_step = '0;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) tick(1'b0, '0, 2'd0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
